// File: rtl/wb_regfile_fwd.sv
// Write-back stage of the MEM/WB interface: selects the write-back value,
// commits it to a 32-entry register file, serves two ID read ports with
// same-cycle write-through bypass, produces EX-stage forwarding selects and
// counts retired register writes.
module wb_regfile_fwd #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  // MEM/WB bundle
  input  logic [DATA_W-1:0] wb_mem_data,
  input  logic [DATA_W-1:0] wb_alu_res,
  input  logic [ADDR_W-1:0] wb_dst,
  input  logic              wb_mem2reg,
  input  logic              wb_regwr,
  // ID read ports
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  // EX forwarding
  input  logic [ADDR_W-1:0] ex_rs,
  input  logic [ADDR_W-1:0] ex_rt,
  input  logic [ADDR_W-1:0] mem_dst,
  input  logic              mem_regwr,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  // Write-back value and retired-write counter
  output logic [DATA_W-1:0] wb_value,
  output logic [31:0]       wb_count
);

  localparam int unsigned CNT_W = 32;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [CNT_W-1:0]  wb_count_q;
  logic [CNT_W-1:0]  wb_count_d;
  logic              commit_c;
  logic              mem_fwd_ok_c;

  // Write-back mux: memory load result or ALU result
  assign wb_value = wb_mem2reg ? wb_mem_data : wb_alu_res;

  // A write retires only when enabled and not targeting the hard-wired r0
  assign commit_c     = wb_regwr && (wb_dst != '0);
  assign mem_fwd_ok_c = mem_regwr && (mem_dst != '0);

  // Counter next value; natural 32-bit wrap
  always_comb begin
    wb_count_d = wb_count_q + CNT_W'(1);
  end

  // Register file and counter; async reset also drops any same-edge commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      wb_count_q <= '0;
    end else if (commit_c) begin
      regs_q[wb_dst] <= wb_value;
      wb_count_q     <= wb_count_d;
    end
  end

  assign wb_count = wb_count_q;

  // Read with write-through: an in-flight commit is visible before the edge
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] val;
    val = '0;
    if (addr != '0) begin
      if (commit_c && (addr == wb_dst)) begin
        val = wb_value;
      end else begin
        val = regs_q[addr];
      end
    end
    return val;
  endfunction

  // Forwarding select: newer EX/MEM producer beats older MEM/WB producer
  function automatic logic [1:0] fwd_sel(input logic [ADDR_W-1:0] src);
    logic [1:0] sel;
    sel = FWD_RF;
    if (mem_fwd_ok_c && (mem_dst == src)) begin
      sel = FWD_MEM;
    end else if (commit_c && (wb_dst == src)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  // ID read ports, forced to zero while reset is held
  always_comb begin
    rd_data_a = '0;
    rd_data_b = '0;
    if (!rst) begin
      rd_data_a = read_port(rd_addr_a);
      rd_data_b = read_port(rd_addr_b);
    end
  end

  // EX operand selects, forced to the regfile path while reset is held
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (!rst) begin
      fwd_a = fwd_sel(ex_rs);
      fwd_b = fwd_sel(ex_rt);
    end
  end

endmodule
